// File: rtl/event_encoder.sv
// Sequential N-to-log2(N) event encoder: sticky pending bits drained one index per valid/ready transfer.
// Define EVENT_ENCODER_RR_EN for round-robin selection; the default build uses fixed highest-index priority.
module event_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] pending_o,
    output logic         overflow_o
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t       state, state_next;
    logic         acc;
    logic [N-1:0] clear_mask, set_mask, cand, pending_next;
    logic         overflow_next, valid_next;
    logic [W-1:0] idx_next, sel_idle, sel_acc;

`ifdef EVENT_ENCODER_RR_EN
    logic [W-1:0] last;

    // Ascending search from start, wrapping naturally through W-bit arithmetic.
    function automatic logic [W-1:0] sel_rr(input logic [N-1:0] vec, input logic [W-1:0] start);
        logic [W-1:0] j;
        logic         found;
        sel_rr = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = start + W'(i);
            if (!found && vec[j]) begin
                sel_rr = j;
                found  = 1'b1;
            end
        end
    endfunction

    // After an accept the pointer becomes idx_o, so that search starts just past it.
    assign sel_idle = sel_rr(pending_o, last + W'(1));
    assign sel_acc  = sel_rr(cand, idx_o + W'(1));
`else
    function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] vec);
        sel_fixed = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) sel_fixed = W'(i);
        end
    endfunction

    assign sel_idle = sel_fixed(pending_o);
    assign sel_acc  = sel_fixed(cand);
`endif

    always_comb begin
        acc           = valid_o & ready_i;
        clear_mask    = acc ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
        set_mask      = en ? req : '0;
        cand          = pending_o & ~clear_mask;
        pending_next  = cand | set_mask;
        // A request re-setting the bit being accepted is a fresh event, not a merge.
        overflow_next = |(set_mask & cand);
        state_next    = state;
        idx_next      = idx_o;
        case (state)
            IDLE: begin
                if (|pending_o) begin
                    idx_next   = sel_idle;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (acc) begin
                    if (|cand) idx_next   = sel_acc;
                    else       state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        valid_next = (state_next == PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid_o    <= 1'b0;
            idx_o      <= '0;
            pending_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            state      <= state_next;
            valid_o    <= valid_next;
            idx_o      <= idx_next;
            pending_o  <= pending_next;
            overflow_o <= overflow_next;
        end
    end

`ifdef EVENT_ENCODER_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   last <= W'(N-1);
        else if (acc) last <= idx_o;
    end
`endif

endmodule
